// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side logic: drain FSM encoding
// and the default word width.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register FIFO. Slot 0 is always the head, so head_data is a plain
// register and stays stable while nothing is popped.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occ,
    output logic                  overflow
);

    logic [DATA_WIDTH-1:0] slot0_q;
    logic [DATA_WIDTH-1:0] slot1_q;
    logic [DATA_WIDTH-1:0] slot0_d;
    logic [DATA_WIDTH-1:0] slot1_d;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  pop_ok;

    assign pop_ok    = pop && (occ_q != 2'd0);
    assign overflow  = push && (occ_q == 2'd2) && !pop_ok;
    assign head_data = slot0_q;
    assign occ       = occ_q;

    always_comb begin
        // NOTE: every always_comb output gets its default first, so no path through the case can infer a latch.
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        occ_d   = occ_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    slot0_d = push_data;
                    occ_d   = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop_ok) begin
                    slot0_d = push_data;
                end else if (push) begin
                    slot1_d = push_data;
                    occ_d   = 2'd2;
                end else if (pop_ok) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                // Full: a push without a pop is dropped and reported as overflow.
                if (pop_ok) begin
                    slot0_d = slot1_q;
                    if (push) begin
                        slot1_d = push_data;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data slots are reset as well, because slot 0 is the registered stream output and must read 0 out of reset.
            slot0_q <= '0;
            slot1_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side consumer of the async FIFO: issues read strobes, absorbs the
// one-cycle read latency in a 2-entry skid buffer and presents a valid/ready stream.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int BURST_MODE    = 1,
    parameter int FLUSH_TIMEOUT = 64,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  clk_r,
    input  logic                  reset_r,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_empty,
    input  logic                  fifo_alm_empty,
    output logic                  fifo_red_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  drain_active,
    output logic                  ovf_err
);

    localparam int TIMER_WIDTH = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = TIMER_WIDTH'(FLUSH_TIMEOUT - 1);

    rd_state_t              state_q;
    rd_state_t              state_d;
    logic                   inflight_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [1:0]             occ;
    logic                   pop;
    logic                   overflow;
    logic                   start_drain;

    assign out_valid    = (occ != 2'd0);
    assign pop          = out_valid && out_ready;
    assign drain_active = (state_q == DRAIN);

    // Words already buffered plus the one in flight must leave room for the next read.
    assign fifo_red_enable = (state_q == DRAIN) && !fifo_empty
                             && (({1'b0, occ} + {2'b00, inflight_q}) < 3'd2);

    // In burst mode the drain waits for a burst, or for trailing words that idled too long.
    assign start_drain = (BURST_MODE == 0) ? !fifo_empty
                       : (!fifo_alm_empty || (!fifo_empty && (timer_q == TIMER_MAX)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_drain) state_d = DRAIN;
            DRAIN: if (fifo_empty && !fifo_red_enable) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_r or negedge reset_r) begin
        if (!reset_r) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            timer_q    <= '0;
            word_count <= '0;
            ovf_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_red_enable;
            if (pop) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end
            if (overflow) begin
                ovf_err <= 1'b1;
            end
            if ((state_q != IDLE) || fifo_empty || (state_d == DRAIN)) begin
                timer_q <= '0;
            end else if (timer_q != TIMER_MAX) begin
                timer_q <= timer_q + TIMER_WIDTH'(1);
            end
        end
    end

    // A word read in the previous cycle is captured unconditionally, even after leaving DRAIN.
    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk_r),
        .rst_n     (reset_r),
        .push      (inflight_q),
        .push_data (fifo_rdata),
        .pop       (pop),
        .head_data (out_data),
        .occ       (occ),
        .overflow  (overflow)
    );

endmodule
